// File: rtl/bluejay_data_if_if.sv
// Bluejay SLM data-port bundle: FIFO read side plus display output pins.
//   slave  : view of the streaming block (bluejay_data_if).
//   master : view of the surrounding logic (FIFO, frame control, pins).
// Signals:
//   next_frame_rdy, line_of_data_available, fifo_empty, fifo_data_out[31:0],
//   invert_o           -> into the streamer
//   get_next_word, data_o[31:0], sync_o, valid_o, update_o -> out of the streamer
interface bluejay_data_if_if;
    localparam int unsigned DATA_W = 32;

    logic              next_frame_rdy;
    logic [DATA_W-1:0] fifo_data_out;
    logic              line_of_data_available;
    logic              fifo_empty;
    logic              invert_o;
    logic              get_next_word;
    logic [DATA_W-1:0] data_o;
    logic              sync_o;
    logic              valid_o;
    logic              update_o;

    modport slave (
        input  next_frame_rdy, fifo_data_out, line_of_data_available,
               fifo_empty, invert_o,
        output get_next_word, data_o, sync_o, valid_o, update_o
    );

    modport master (
        output next_frame_rdy, fifo_data_out, line_of_data_available,
               fifo_empty, invert_o,
        input  get_next_word, data_o, sync_o, valid_o, update_o
    );
endinterface

// File: rtl/bluejay_data_if.sv
// Streams pixel words from the line-buffer FIFO to the Bluejay SLM data port.
// A frame starts on next_frame_rdy; each line emits one sync_o strobe followed
// by WORDS_PER_LINE valid_o words; after the last line update_o pulses for
// UPDATE_CYCLES clocks.
// Ports:
//   fpga_clk  : clock, rising edge
//   reset_all : asynchronous active-low reset
//   bus       : bluejay_data_if_if.slave (FIFO read side + display pins)
// Optional: define BLUEJAY_INVERT_EN to XOR pixel data with invert_o;
//   otherwise invert_o is ignored and data passes through unmodified.
module bluejay_data_if #(
    parameter int unsigned WORDS_PER_LINE  = 40,
    parameter int unsigned LINES_PER_FRAME = 1024,
    parameter int unsigned UPDATE_CYCLES   = 2
) (
    input  logic                fpga_clk,
    input  logic                reset_all,
    bluejay_data_if_if.slave    bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = (WORDS_PER_LINE  > 1) ? $clog2(WORDS_PER_LINE)  : 1;
    localparam int unsigned LINE_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam int unsigned AUX_W  = $clog2(UPDATE_CYCLES + 2);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        LINE,
        DRAIN,
        UPDATE
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic [AUX_W-1:0]    aux_cnt_q, aux_cnt_d;
    logic                rd_q;
    logic                sync_q, sync_d;
    logic                valid_q, valid_d;
    logic                update_q, update_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   pix_c;
    logic                rd_c;

    // Pixel word as presented by the FIFO one cycle after the read.
`ifdef BLUEJAY_INVERT_EN
    assign pix_c = bus.fifo_data_out ^ {DATA_W{bus.invert_o}};
`else
    logic unused_invert;
    assign unused_invert = bus.invert_o;
    assign pix_c = bus.fifo_data_out;
`endif

    // Next-state, counters and output pipeline.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        aux_cnt_d  = aux_cnt_q;
        rd_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.next_frame_rdy) begin
                    state_d    = WAIT_LINE;
                    line_cnt_d = '0;
                end
            end
            WAIT_LINE: begin
                if (bus.line_of_data_available && !bus.fifo_empty) begin
                    state_d    = LINE;
                    word_cnt_d = '0;
                end
            end
            LINE: begin
                // Empty FIFO simply stalls the line; the count holds.
                rd_c = ~bus.fifo_empty;
                if (rd_c) begin
                    word_cnt_d = word_cnt_q + WORD_W'(1);
                    if (word_cnt_q == WORD_W'(WORDS_PER_LINE - 1)) begin
                        state_d   = DRAIN;
                        aux_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                // Two cycles let the last word reach data_o.
                aux_cnt_d = aux_cnt_q + AUX_W'(1);
                if (aux_cnt_q == AUX_W'(1)) begin
                    aux_cnt_d = '0;
                    if (line_cnt_q == LINE_W'(LINES_PER_FRAME - 1)) begin
                        state_d = UPDATE;
                    end else begin
                        state_d    = WAIT_LINE;
                        line_cnt_d = line_cnt_q + LINE_W'(1);
                    end
                end
            end
            UPDATE: begin
                aux_cnt_d = aux_cnt_q + AUX_W'(1);
                if (aux_cnt_q == AUX_W'(UPDATE_CYCLES - 1)) begin
                    aux_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sync precedes the first valid word, so it tracks the first actual read.
        sync_d   = rd_c && (word_cnt_q == '0);
        valid_d  = rd_q;
        data_d   = rd_q ? pix_c : data_q;
        update_d = (state_d == UPDATE);
    end

    always_ff @(posedge fpga_clk or negedge reset_all) begin
        if (!reset_all) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            aux_cnt_q  <= '0;
            rd_q       <= 1'b0;
            sync_q     <= 1'b0;
            valid_q    <= 1'b0;
            update_q   <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            aux_cnt_q  <= aux_cnt_d;
            rd_q       <= rd_c;
            sync_q     <= sync_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            data_q     <= data_d;
        end
    end

    // FIFO read enable is combinational so a newly empty FIFO is never read.
    assign bus.get_next_word = rd_c;
    assign bus.data_o        = data_q;
    assign bus.sync_o        = sync_q;
    assign bus.valid_o       = valid_q;
    assign bus.update_o      = update_q;
endmodule

// File: tb/tb_bluejay_data_if.sv
// Directed bench for bluejay_data_if: instance a (4 words x 1 line) and
// instance b (4 words x 3 lines) share control inputs; each has its own
// FIFO model returning 1, 2, 3, ... on successive reads.
module tb_bluejay_data_if;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic rdy = 1'b0, lavail = 1'b0, empty = 1'b1, inv = 1'b0;
    int total = 0, bad = 0;

    bluejay_data_if_if a_if ();
    bluejay_data_if_if b_if ();

    assign a_if.next_frame_rdy = rdy;
    assign a_if.line_of_data_available = lavail;
    assign a_if.fifo_empty = empty;
    assign a_if.invert_o = inv;
    assign b_if.next_frame_rdy = rdy;
    assign b_if.line_of_data_available = lavail;
    assign b_if.fifo_empty = empty;
    assign b_if.invert_o = inv;

    bluejay_data_if #(.WORDS_PER_LINE(4), .LINES_PER_FRAME(1), .UPDATE_CYCLES(2)) u_a (
        .fpga_clk(clk), .reset_all(rst_n), .bus(a_if));
    bluejay_data_if #(.WORDS_PER_LINE(4), .LINES_PER_FRAME(3), .UPDATE_CYCLES(2)) u_b (
        .fpga_clk(clk), .reset_all(rst_n), .bus(b_if));

    // FIFO models: read k returns k on the following cycle.
    logic [31:0] a_rdn, b_rdn, a_fd, b_fd;
    assign a_if.fifo_data_out = a_fd;
    assign b_if.fifo_data_out = b_fd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdn <= 0; a_fd <= 0; b_rdn <= 0; b_fd <= 0;
        end else begin
            if (a_if.get_next_word) begin a_rdn <= a_rdn + 1; a_fd <= a_rdn + 1; end
            if (b_if.get_next_word) begin b_rdn <= b_rdn + 1; b_fd <= b_rdn + 1; end
        end
    end

    // Monitors, sampled on the falling edge.
    int cyc = 0;
    int a_gnw, a_val, a_syn, a_updc, a_updr, a_viol, a_upd_first;
    int b_gnw, b_val, b_syn, b_updc, b_updr, b_upd_first, b_last_val;
    logic a_upd_prev, b_upd_prev;
    logic [31:0] a_dq[$], b_dq[$];
    int a_vc[$], a_sc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            a_gnw <= 0; a_val <= 0; a_syn <= 0; a_updc <= 0; a_updr <= 0; a_viol <= 0;
            a_upd_first <= 0; a_upd_prev <= 1'b0;
            b_gnw <= 0; b_val <= 0; b_syn <= 0; b_updc <= 0; b_updr <= 0;
            b_upd_first <= 0; b_last_val <= 0; b_upd_prev <= 1'b0;
            a_dq.delete(); b_dq.delete(); a_vc.delete(); a_sc.delete();
        end else begin
            if (a_if.get_next_word) a_gnw <= a_gnw + 1;
            if (a_if.get_next_word && empty) a_viol <= a_viol + 1;
            if (a_if.valid_o) begin a_val <= a_val + 1; a_dq.push_back(a_if.data_o); a_vc.push_back(cyc); end
            if (a_if.sync_o) begin a_syn <= a_syn + 1; a_sc.push_back(cyc); end
            if (a_if.update_o) a_updc <= a_updc + 1;
            if (a_if.update_o && !a_upd_prev) begin a_updr <= a_updr + 1; a_upd_first <= cyc; end
            a_upd_prev <= a_if.update_o;
            if (b_if.get_next_word) b_gnw <= b_gnw + 1;
            if (b_if.valid_o) begin b_val <= b_val + 1; b_dq.push_back(b_if.data_o); b_last_val <= cyc; end
            if (b_if.sync_o) b_syn <= b_syn + 1;
            if (b_if.update_o) b_updc <= b_updc + 1;
            if (b_if.update_o && !b_upd_prev) begin b_updr <= b_updr + 1; b_upd_first <= cyc; end
            b_upd_prev <= b_if.update_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step(2); rst_n = 1'b1; step(1);
    endtask

    logic [31:0] mask;

    initial begin
`ifdef BLUEJAY_INVERT_EN
        mask = 32'hFFFF_FFFF;
`else
        mask = 32'h0;
`endif
        // 1: reset in the middle of a line, then stay idle
        step(2); rst_n = 1'b1;
        empty = 1'b0; lavail = 1'b1;
        rdy = 1'b1; step(1); rdy = 1'b0; step(3);
        rst_n = 1'b0; #1;
        check("rst_data", a_if.data_o, 32'h0);
        check("rst_valid", 32'(a_if.valid_o), 32'h0);
        check("rst_sync", 32'(a_if.sync_o), 32'h0);
        check("rst_update", 32'(a_if.update_o), 32'h0);
        check("rst_gnw", 32'(a_if.get_next_word), 32'h0);
        step(2); rst_n = 1'b1; step(10);
        check("idle_gnw", 32'(a_gnw), 32'd0);
        check("idle_valid", 32'(a_val), 32'd0);

        // 2: single line, no invert
        do_reset(); inv = 1'b0;
        rdy = 1'b1; step(1); rdy = 1'b0; step(30);
        check("t2_gnw", 32'(a_gnw), 32'd4);
        check("t2_valid", 32'(a_val), 32'd4);
        check("t2_sync", 32'(a_syn), 32'd1);
        check("t2_upd_cycles", 32'(a_updc), 32'd2);
        check("t2_upd_pulses", 32'(a_updr), 32'd1);
        for (int i = 0; i < 4; i++) check("t2_data", a_dq[i], 32'(i + 1));
        check("t2_sync_lead", 32'(a_vc[0] - a_sc[0]), 32'd1);
        check("t2_valid_run", 32'(a_vc[3] - a_vc[0]), 32'd3);
        check("t2_upd_after", 32'(a_upd_first - a_vc[3]), 32'd1);

        // 3: invert
        do_reset(); inv = 1'b1;
        rdy = 1'b1; step(1); rdy = 1'b0; step(30); inv = 1'b0;
        check("t3_valid", 32'(a_val), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_data", a_dq[i], 32'(i + 1) ^ mask);

        // 4: FIFO underflow after the second read
        do_reset();
        rdy = 1'b1; step(1); rdy = 1'b0;
        for (int i = 0; i < 50 && a_rdn != 2; i++) step(1);
        check("t4_reach2", a_rdn, 32'd2);
        empty = 1'b1; step(3); empty = 1'b0; step(30);
        check("t4_gnw", 32'(a_gnw), 32'd4);
        check("t4_valid", 32'(a_val), 32'd4);
        check("t4_sync", 32'(a_syn), 32'd1);
        check("t4_gap", 32'(a_vc[2] - a_vc[1]), 32'd4);
        check("t4_data2", a_dq[2], 32'd3);
        check("t4_data3", a_dq[3], 32'd4);
        check("t4_read_empty", 32'(a_viol), 32'd0);
        check("t4_upd_pulses", 32'(a_updr), 32'd1);

        // 5: three lines, line data delayed before line 2
        do_reset();
        rdy = 1'b1; step(1); rdy = 1'b0;
        for (int i = 0; i < 50 && b_gnw < 1; i++) step(1);
        check("t5_started", 32'(b_gnw > 0), 32'd1);
        lavail = 1'b0; step(10);
        check("t5_hold_gnw", 32'(b_gnw), 32'd4);
        check("t5_hold_upd", 32'(b_updr), 32'd0);
        lavail = 1'b1; step(60);
        check("t5_sync", 32'(b_syn), 32'd3);
        check("t5_valid", 32'(b_val), 32'd12);
        check("t5_gnw", 32'(b_gnw), 32'd12);
        check("t5_upd_pulses", 32'(b_updr), 32'd1);
        check("t5_upd_cycles", 32'(b_updc), 32'd2);
        check("t5_data4", b_dq[4], 32'd5);
        check("t5_data11", b_dq[11], 32'd12);
        check("t5_upd_after", 32'(b_upd_first - b_last_val), 32'd1);

        // 6: next_frame_rdy held high -> back-to-back frames every 10 cycles
        do_reset();
        rdy = 1'b1; step(30); rdy = 1'b0; step(20);
        check("t6_sync", 32'(a_syn), 32'd3);
        check("t6_gnw", 32'(a_gnw), 32'd12);
        check("t6_upd_pulses", 32'(a_updr), 32'd3);
        check("t6_upd_cycles", 32'(a_updc), 32'd6);
        check("t6_period", 32'(a_sc[1] - a_sc[0]), 32'd10);

        // 6b: a frame request during LINE is ignored
        do_reset();
        rdy = 1'b1; step(1); rdy = 1'b0;
        for (int i = 0; i < 50 && a_gnw < 1; i++) step(1);
        rdy = 1'b1; step(1); rdy = 1'b0; step(30);
        check("t6b_sync", 32'(a_syn), 32'd1);
        check("t6b_gnw", 32'(a_gnw), 32'd4);
        check("t6b_upd_pulses", 32'(a_updr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
